// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store bus controller with stall, alignment and timeout
module mem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata,
  output logic        mem_stall_MEM,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    ld_off;
  logic [1:0]    ld_size;
  logic          ld_uns;

  logic          mem_op;
  logic          access;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;

  assign mem_op   = mem_read | mem_write;
  assign addr_err = mem_op & (((mem_size == 2'd1) & addr[0]) |
                              ((mem_size >= 2'd2) & (addr[1:0] != 2'b00)));
  assign access   = mem_op & ~addr_err & ~flush;

  assign mem_stall_MEM = ((state == IDLE) & access) | (state == BUSY);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (mem_size)
      2'd0: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      2'd1: begin
        be_next    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata;
      end
    endcase
  end

  // Lane select then extend; halves are aligned so a byte-granular shift also works for them.
  function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (sz)
      2'd0:    res = {{24{~uns & sh[7]}}, sh[7:0]};
      2'd1:    res = {{16{~uns & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      rdata     <= 32'd0;
      bus_err   <= 1'b0;
      ld_off    <= 2'd0;
      ld_size   <= 2'd0;
      ld_uns    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_next;
            bus_we    <= mem_write;
            bus_wdata <= wdata_next;
            bus_req   <= 1'b1;
            ld_off    <= addr[1:0];
            ld_size   <= mem_size;
            ld_uns    <= mem_unsigned;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // flush is deliberately ignored here: the bus cycle must complete.
          if (bus_ack) begin
            if (!bus_we) begin
              rdata <= fmt_load(bus_rdata, ld_off, ld_size, ld_uns);
            end
            bus_req <= 1'b0;
            state   <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            rdata   <= 32'd0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus_err <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table-driven bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, mem_unsigned, flush;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, rdata;
  logic [3:0]  bus_be;
  logic        mem_stall_MEM, addr_err, bus_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
    .flush(flush), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rdata(rdata), .mem_stall_MEM(mem_stall_MEM), .addr_err(addr_err), .bus_err(bus_err)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic        fl;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] brd;
    int          ack_at;
    logic        exp_aerr;
    logic        exp_access;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read = 0; mem_write = 0; mem_size = 0; mem_unsigned = 0; flush = 0;
    addr = 0; wdata = 0; bus_ack = 0; bus_rdata = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int stall_cycles;
    @(posedge clk); #1;
    mem_read = v.rd; mem_write = v.wr; mem_size = v.size; mem_unsigned = v.uns;
    flush = v.fl; addr = v.a; wdata = v.wd;
    @(negedge clk);
    chk({v.name, ".addr_err"}, 32'(addr_err), 32'(v.exp_aerr));
    chk({v.name, ".stall_idle"}, 32'(mem_stall_MEM), 32'(v.exp_access));
    stall_cycles = mem_stall_MEM ? 1 : 0;
    if (v.exp_access) begin
      for (int k = 1; k <= v.ack_at; k++) begin
        @(posedge clk); #1;
        if (k == v.ack_at) begin bus_ack = 1; bus_rdata = v.brd; end
        @(negedge clk);
        if (mem_stall_MEM) stall_cycles++;
        chk({v.name, ".bus_req"}, 32'(bus_req), 32'd1);
        if (k == 1) begin
          chk({v.name, ".bus_we"}, 32'(bus_we), 32'(v.wr));
          chk({v.name, ".bus_addr"}, bus_addr, v.exp_baddr);
          chk({v.name, ".bus_be"}, 32'(bus_be), 32'(v.exp_be));
          if (v.wr) chk({v.name, ".bus_wdata"}, bus_wdata, v.exp_wdata);
        end
      end
      @(posedge clk); #1;
      bus_ack = 0; bus_rdata = 32'h5A5A_5A5A;
      @(negedge clk);
      chk({v.name, ".stall_cycles"}, 32'(stall_cycles), 32'(1 + v.ack_at));
      chk({v.name, ".stall_done"}, 32'(mem_stall_MEM), 32'd0);
      chk({v.name, ".req_done"}, 32'(bus_req), 32'd0);
      chk({v.name, ".bus_err"}, 32'(bus_err), 32'd0);
      if (v.rd) chk({v.name, ".rdata"}, rdata, v.exp_rdata);
    end else begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk({v.name, ".no_req"}, 32'(bus_req), 32'd0);
        chk({v.name, ".no_stall"}, 32'(mem_stall_MEM), 32'd0);
      end
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    int busy;
    logic [31:0] held;
    clear_inputs();
    rst_n = 0;
    #2;
    chk("reset.bus_req", 32'(bus_req), 32'd0);
    chk("reset.bus_be", 32'(bus_be), 32'd0);
    chk("reset.bus_addr", bus_addr, 32'd0);
    chk("reset.rdata", rdata, 32'd0);
    chk("reset.bus_err", 32'(bus_err), 32'd0);
    chk("reset.stall", 32'(mem_stall_MEM), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;

    //           name    rd wr sz un fl addr          wdata         bus_rdata   ack aerr acc baddr        be       wdata         rdata
    vecs.push_back('{"lw",    1,0,2,0,0,32'h0000_1004,32'h0,        32'hDEADBEEF,3,0,1,32'h0000_1004,4'b1111,32'h0,        32'hDEADBEEF});
    vecs.push_back('{"lb",    1,0,0,0,0,32'h0000_1003,32'h0,        32'h80FF0000,1,0,1,32'h0000_1000,4'b1000,32'h0,        32'hFFFFFF80});
    vecs.push_back('{"lbu",   1,0,0,1,0,32'h0000_1003,32'h0,        32'h80FF0000,1,0,1,32'h0000_1000,4'b1000,32'h0,        32'h00000080});
    vecs.push_back('{"sh",    0,1,1,0,0,32'h0000_2002,32'h0000ABCD, 32'h0,       2,0,1,32'h0000_2000,4'b1100,32'hABCDABCD, 32'h0});
    vecs.push_back('{"lw_mis",1,0,2,0,0,32'h0000_1002,32'h0,        32'h0,       1,1,0,32'h0,        4'b0000,32'h0,        32'h0});
    vecs.push_back('{"lw_fl", 1,0,2,0,1,32'h0000_1000,32'h0,        32'h0,       1,0,0,32'h0,        4'b0000,32'h0,        32'h0});
    vecs.push_back('{"lh",    1,0,1,0,0,32'h0000_1002,32'h0,        32'h80011234,2,0,1,32'h0000_1000,4'b1100,32'h0,        32'hFFFF8001});
    vecs.push_back('{"lhu",   1,0,1,1,0,32'h0000_1000,32'h0,        32'h1234F00D,1,0,1,32'h0000_1000,4'b0011,32'h0,        32'h0000F00D});
    vecs.push_back('{"sb",    0,1,0,0,0,32'h0000_3001,32'h123456A5, 32'h0,       1,0,1,32'h0000_3000,4'b0010,32'hA5A5A5A5, 32'h0});
    vecs.push_back('{"sw",    0,1,2,0,0,32'h0000_4008,32'hCAFEF00D, 32'h0,       4,0,1,32'h0000_4008,4'b1111,32'hCAFEF00D, 32'h0});
    vecs.push_back('{"lb1",   1,0,0,0,0,32'h0000_1001,32'h0,        32'h00007F00,1,0,1,32'h0000_1000,4'b0010,32'h0,        32'h0000007F});
    vecs.push_back('{"sh_mis",0,1,1,0,0,32'h0000_2001,32'h0000FFFF, 32'h0,       1,1,0,32'h0,        4'b0000,32'h0,        32'h0});
    vecs.push_back('{"lrsv",  1,0,3,0,0,32'h0000_1004,32'h0,        32'h11223344,1,0,1,32'h0000_1004,4'b1111,32'h0,        32'h11223344});

    foreach (vecs[i]) run_vec(vecs[i]);

    // stray ack while idle must not touch rdata
    held = rdata;
    @(posedge clk); #1; bus_ack = 1; bus_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1; bus_ack = 0;
    @(negedge clk);
    chk("idle_ack.rdata", rdata, held);
    chk("idle_ack.req", 32'(bus_req), 32'd0);

    // timeout: no ack at all
    @(posedge clk); #1;
    mem_read = 1; mem_size = 2; addr = 32'h0000_5000;
    @(negedge clk);
    chk("to.stall_idle", 32'(mem_stall_MEM), 32'd1);
    busy = 0;
    do begin
      @(negedge clk);
      if (bus_req) busy++;
    end while (bus_req && busy < 4 * TIMEOUT);
    chk("to.busy_cycles", 32'(busy), 32'(TIMEOUT));
    chk("to.bus_err", 32'(bus_err), 32'd1);
    chk("to.rdata", rdata, 32'd0);
    chk("to.stall_done", 32'(mem_stall_MEM), 32'd0);
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    chk("to.err_cleared", 32'(bus_err), 32'd0);

    // flush during BUSY is ignored; load still captured
    @(posedge clk); #1;
    mem_read = 1; mem_size = 2; addr = 32'h0000_6000;
    @(posedge clk); #1; flush = 1;
    @(posedge clk); #1; bus_ack = 1; bus_rdata = 32'h0BADF00D;
    @(posedge clk); #1; bus_ack = 0;
    @(negedge clk);
    chk("fl_busy.req", 32'(bus_req), 32'd0);
    chk("fl_busy.rdata", rdata, 32'h0BADF00D);
    @(posedge clk); #1; clear_inputs();

    // asynchronous reset mid-BUSY
    @(posedge clk); #1;
    mem_read = 1; mem_size = 2; addr = 32'h0000_7000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy.req_before", 32'(bus_req), 32'd1);
    #1; rst_n = 0; mem_read = 0;
    #1;
    chk("rst_busy.req", 32'(bus_req), 32'd0);
    chk("rst_busy.stall", 32'(mem_stall_MEM), 32'd0);
    chk("rst_busy.rdata", rdata, 32'd0);
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy.idle", 32'(bus_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
